mem_arbiter: RTL and testbench

Two-requester arbiter that shares one single-ported memory bus between instruction fetch (IF) and load/store (MEM). It sits between the fetch/memory stages and the RAM model and replaces the dual-read-port RAM arrangement. Each request goes through one registered transaction on the shared bus, with a req/ack handshake on every side. Data accesses have priority; a starvation counter guarantees forward progress for fetch.

---
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory bus between instruction
// fetch (IF) and load/store (MEM). Each request becomes exactly one
// registered bus transaction: IDLE -> BUS_x -> RESP -> IDLE.
// MEM has priority. A saturating starvation counter forces an IF win after
// STARVE_MAX consecutive lost arbitrations.
//
// Ports:
//   clk, rst                  clock, async active-high reset
//   if_req/if_addr            fetch request, held until if_ack
//   if_ack/if_rdata           one-cycle ack, selected 32-bit word
//   mem_req/we/addr/wdata/wstrb  data request, held until mem_ack
//   mem_ack/mem_rdata         one-cycle ack, raw 64-bit word
//   bus_req/we/addr/wdata/wstrb  registered memory-side request
//   bus_ack/bus_rdata         memory completion and read data
//   busy                      high whenever not IDLE
module mem_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [63:0] mem_addr,
  input  logic [63:0] mem_wdata,
  input  logic [7:0]  mem_wstrb,
  output logic        mem_ack,
  output logic [63:0] mem_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [63:0] bus_rdata,
  output logic        busy
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUS_IF, BUS_MEM, RESP} state_t;

  state_t      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [63:0] bus_addr_q, bus_addr_d;
  logic [63:0] bus_wdata_q, bus_wdata_d;
  logic [7:0]  bus_wstrb_q, bus_wstrb_d;
  logic        word_sel_q, word_sel_d;
  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        if_ack_q, if_ack_d;
  logic        mem_ack_q, mem_ack_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic [63:0] mem_rdata_q, mem_rdata_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_wstrb_q  <= '0;
      word_sel_q   <= 1'b0;
      starve_cnt_q <= '0;
      if_ack_q     <= 1'b0;
      mem_ack_q    <= 1'b0;
      if_rdata_q   <= '0;
      mem_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_wstrb_q  <= bus_wstrb_d;
      word_sel_q   <= word_sel_d;
      starve_cnt_q <= starve_cnt_d;
      if_ack_q     <= if_ack_d;
      mem_ack_q    <= mem_ack_d;
      if_rdata_q   <= if_rdata_d;
      mem_rdata_q  <= mem_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_wstrb_d  = bus_wstrb_q;
    word_sel_d   = word_sel_q;
    starve_cnt_d = starve_cnt_q;
    if_ack_d     = 1'b0;
    mem_ack_d    = 1'b0;
    if_rdata_d   = if_rdata_q;
    mem_rdata_d  = mem_rdata_q;

    unique case (state_q)
      IDLE: begin
        // MEM wins unless IF has already lost STARVE_MAX times in a row.
        if (mem_req && !(if_req && starve_cnt_q == STARVE_LIM)) begin
          state_d     = BUS_MEM;
          bus_req_d   = 1'b1;
          bus_we_d    = mem_we;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_wstrb_d = mem_wstrb;
          // Counter is below the limit here whenever IF is waiting, so a
          // plain increment already saturates at STARVE_MAX.
          if (if_req) starve_cnt_d = starve_cnt_q + 4'd1;
        end else if (if_req) begin
          state_d      = BUS_IF;
          bus_req_d    = 1'b1;
          bus_we_d     = 1'b0;
          bus_addr_d   = if_addr;
          bus_wdata_d  = '0;
          bus_wstrb_d  = '0;
          word_sel_d   = if_addr[2];
          starve_cnt_d = '0;
        end
      end
      BUS_IF, BUS_MEM: begin
        if (bus_ack) begin
          state_d     = RESP;
          bus_req_d   = 1'b0;
          if_ack_d    = (state_q == BUS_IF);
          mem_ack_d   = (state_q == BUS_MEM);
          // Both read views refresh on every completion and then hold.
          mem_rdata_d = bus_rdata;
          if_rdata_d  = word_sel_q ? bus_rdata[63:32] : bus_rdata[31:0];
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign if_ack    = if_ack_q;
  assign mem_ack   = mem_ack_q;
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_wstrb = bus_wstrb_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req, mem_we;
  logic [63:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        bus_req, bus_we;
  logic [63:0] bus_addr, bus_wdata;
  logic [7:0]  bus_wstrb;
  logic        bus_ack;
  logic [63:0] bus_rdata;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  mem_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [327:0] all_out;
    logic saw_ack;
    all_out = {bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_ack, mem_ack,
               if_rdata, mem_rdata, busy};
    n_cmp++; if (all_out !== '0) begin n_err++;
      $display("FAIL reset_outputs: got %h expected 0", all_out); end
    n_cmp++; if (dut.starve_cnt_q !== 4'd0) begin n_err++;
      $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt_q); end
    rst = 1'b0;
    tick();
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h2000;
    mem_wdata = 64'h1234; mem_wstrb = 8'hFF; bus_ack = 1'b0;
    tick();
    n_cmp++; if (bus_req !== 1'b1 || busy !== 1'b1) begin n_err++;
      $display("FAIL abort_setup: got req=%b busy=%b expected 1 1", bus_req, busy); end
    #2 rst = 1'b1;
    #1;
    all_out = {bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_ack, mem_ack,
               if_rdata, mem_rdata, busy};
    n_cmp++; if (all_out !== '0) begin n_err++;
      $display("FAIL abort_async: got %h expected 0", all_out); end
    mem_req = 1'b0;
    tick();
    rst = 1'b0;
    saw_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (mem_ack === 1'b1 || bus_req === 1'b1) saw_ack = 1'b1;
    end
    n_cmp++; if (saw_ack !== 1'b0) begin n_err++;
      $display("FAIL abort_no_ack: got %b expected 0", saw_ack); end
  endtask

  task automatic test_single_fetch();
    bus_ack = 1'b1; bus_rdata = 64'h1111_2222_3333_4444;
    if_req = 1'b1; if_addr = 64'h8000_0004;
    tick();
    n_cmp++; if (bus_req !== 1'b1 || bus_addr !== 64'h8000_0004 || bus_we !== 1'b0
                 || if_ack !== 1'b0) begin n_err++;
      $display("FAIL fetch_c1: got req=%b addr=%h we=%b ack=%b expected 1 80000004 0 0",
               bus_req, bus_addr, bus_we, if_ack); end
    tick();
    n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h1111_2222 || mem_ack !== 1'b0)
      begin n_err++;
      $display("FAIL fetch_c2: got ack=%b rdata=%h mack=%b expected 1 11112222 0",
               if_ack, if_rdata, mem_ack); end
    if_req = 1'b0;
    tick();
    n_cmp++; if (if_ack !== 1'b0 || busy !== 1'b0 || if_rdata !== 32'h1111_2222)
      begin n_err++;
      $display("FAIL fetch_c3: got ack=%b busy=%b rdata=%h expected 0 0 11112222",
               if_ack, busy, if_rdata); end
  endtask

  task automatic test_store_wait();
    logic bad;
    bus_ack = 1'b0; bus_rdata = 64'hCAFE_0000_F00D_0000;
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 64'h8000_1000;
    mem_wdata = 64'h0000_0000_DEAD_BEEF; mem_wstrb = 8'h0F;
    tick();
    // Requester payload changes while waiting must not reach the bus.
    mem_addr = 64'h9999; mem_wdata = '1; mem_wstrb = 8'hF0; mem_we = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 64'h8000_1000 ||
          bus_wdata !== 64'h0000_0000_DEAD_BEEF || bus_wstrb !== 8'h0F ||
          mem_ack !== 1'b0 || if_ack !== 1'b0) bad = 1'b1;
      if (i < 2) tick();
    end
    n_cmp++; if (bad !== 1'b0) begin n_err++;
      $display("FAIL store_hold: got bad=%b addr=%h wdata=%h expected stable payload",
               bad, bus_addr, bus_wdata); end
    bus_ack = 1'b1;
    tick();
    n_cmp++; if (mem_ack !== 1'b1 || mem_rdata !== 64'hCAFE_0000_F00D_0000 ||
                 if_ack !== 1'b0 || bus_req !== 1'b0) begin n_err++;
      $display("FAIL store_ack: got ack=%b rdata=%h iack=%b req=%b expected 1 cafe0000f00d0000 0 0",
               mem_ack, mem_rdata, if_ack, bus_req); end
    mem_req = 1'b0; bus_ack = 1'b0;
    tick();
    n_cmp++; if (mem_ack !== 1'b0 || busy !== 1'b0) begin n_err++;
      $display("FAIL store_pulse: got ack=%b busy=%b expected 0 0", mem_ack, busy); end
  endtask

  task automatic test_priority();
    bus_ack = 1'b1; bus_rdata = 64'h5555_6666_7777_8888;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h3000; mem_wdata = '0; mem_wstrb = '0;
    if_req = 1'b1; if_addr = 64'h8000_0010;
    tick();
    n_cmp++; if (bus_addr !== 64'h3000 || dut.starve_cnt_q !== 4'd1) begin n_err++;
      $display("FAIL prio_mem_first: got addr=%h cnt=%0d expected 3000 1",
               bus_addr, dut.starve_cnt_q); end
    tick();
    n_cmp++; if (mem_ack !== 1'b1 || if_ack !== 1'b0) begin n_err++;
      $display("FAIL prio_mem_ack: got mack=%b iack=%b expected 1 0", mem_ack, if_ack); end
    mem_req = 1'b0;
    tick();
    tick();
    n_cmp++; if (bus_addr !== 64'h8000_0010 || dut.starve_cnt_q !== 4'd0) begin n_err++;
      $display("FAIL prio_if_second: got addr=%h cnt=%0d expected 80000010 0",
               bus_addr, dut.starve_cnt_q); end
    tick();
    n_cmp++; if (if_ack !== 1'b1 || if_rdata !== 32'h7777_8888 || mem_ack !== 1'b0)
      begin n_err++;
      $display("FAIL prio_if_ack: got ack=%b rdata=%h mack=%b expected 1 77778888 0",
               if_ack, if_rdata, mem_ack); end
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starvation();
    bus_ack = 1'b1; bus_rdata = 64'h0;
    if_req = 1'b1; if_addr = 64'h8000_0020;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 64'h4000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (bus_addr !== mem_addr || dut.starve_cnt_q !== 4'(k + 1)) begin n_err++;
        $display("FAIL starve_mem_grant%0d: got addr=%h cnt=%0d expected %h %0d",
                 k, bus_addr, dut.starve_cnt_q, mem_addr, k + 1); end
      tick();
      n_cmp++; if (mem_ack !== 1'b1 || if_ack !== 1'b0) begin n_err++;
        $display("FAIL starve_mem_ack%0d: got mack=%b iack=%b expected 1 0",
                 k, mem_ack, if_ack); end
      mem_addr = mem_addr + 64'd8;
      tick();
    end
    tick();
    n_cmp++; if (bus_addr !== 64'h8000_0020 || dut.starve_cnt_q !== 4'd0) begin n_err++;
      $display("FAIL starve_if_grant: got addr=%h cnt=%0d expected 80000020 0",
               bus_addr, dut.starve_cnt_q); end
    tick();
    n_cmp++; if (if_ack !== 1'b1 || mem_ack !== 1'b0) begin n_err++;
      $display("FAIL starve_if_ack: got iack=%b mack=%b expected 1 0", if_ack, mem_ack); end
    if_req = 1'b0; mem_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    int last, waited;
    logic [31:0] exp;
    last = 0;
    bus_ack = 1'b1; bus_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
    if_req = 1'b1; if_addr = 64'h1000;
    for (int i = 0; i < 4; i++) begin
      waited = 0;
      do begin tick(); waited++; end while (if_ack !== 1'b1 && waited < 8);
      exp = if_addr[2] ? 32'hAAAA_BBBB : 32'hCCCC_DDDD;
      n_cmp++; if (if_ack !== 1'b1 || if_rdata !== exp) begin n_err++;
        $display("FAIL b2b_data%0d: got ack=%b rdata=%h expected 1 %h",
                 i, if_ack, if_rdata, exp); end
      if (i > 0) begin
        n_cmp++; if (cyc - last !== 3) begin n_err++;
          $display("FAIL b2b_gap%0d: got %0d expected 3", i, cyc - last); end
      end
      last = cyc;
      if_addr = if_addr + 64'd4;
    end
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    bus_ack = 1'b0; bus_rdata = '0;
    tick(); tick();
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_priority();
    test_starvation();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
